// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM encoding, default FFT sizing and a width helper.
package fft_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fsm_state_e;
  localparam int FFT_N_LOG2 = 4;
  localparam int FFT_RD_LAT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 DIT butterfly addressing, (stage, k) -> (a, b, twiddle).
module fft_addr_gen import fft_pkg::*; #(
  parameter int N_LOG2 = FFT_N_LOG2
) (
  input  logic [N_LOG2-1:0] s,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] a,
  output logic [N_LOG2-1:0] b,
  output logic [N_LOG2-2:0] tw
);
  logic [N_LOG2-1:0] kx, span, pos, sh;
  always_comb begin
    kx   = {1'b0, k};
    span = N_LOG2'(1) << s;
    pos  = kx & (span - 1'b1);
    a    = ((kx >> s) << (s + 1'b1)) | pos;
    b    = a + span;
    sh   = N_LOG2'(N_LOG2 - 1) - s;
    tw   = pos[N_LOG2-2:0] << sh;
  end
endmodule

// File: rtl/fft_stage_seq.sv
// fft_stage_seq: in-place radix-2 FFT sequencer issuing one butterfly per cycle,
// with a read-latency delay line producing the matching write-back.
module fft_stage_seq import fft_pkg::*; #(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int RD_LAT = FFT_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic [N_LOG2-1:0] stage
);
  localparam int CW = clog2(RD_LAT);
  fsm_state_e state_q, state_d;
  logic [N_LOG2-2:0] k_q, k_d;
  logic [N_LOG2-1:0] stage_q, stage_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RD_LAT-1:0] den_q, den_d;
  logic [RD_LAT-1:0][N_LOG2-1:0] dwa_q, dwa_d, dwb_q, dwb_d;
  logic [N_LOG2-1:0] a, b;
  logic [N_LOG2-2:0] tw;
  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr (.s(stage_q), .k(k_q), .a(a), .b(b), .tw(tw));
  assign rd_en     = state_q == S_RUN;
  assign rd_addr_a = rd_en ? a : '0;
  assign rd_addr_b = rd_en ? b : '0;
  assign tw_addr   = rd_en ? tw : '0;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign stage     = stage_q;
  assign wr_en     = den_q[RD_LAT-1];
  assign wr_addr_a = dwa_q[RD_LAT-1];
  assign wr_addr_b = dwb_q[RD_LAT-1];
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        k_d     = '0;
        stage_d = '0;
      end
      S_RUN: begin
        k_d = k_q + 1'b1;
        if (&k_q) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d = (stage_q == N_LOG2'(N_LOG2 - 1)) ? S_DONE : S_RUN;
          stage_d = (stage_q == N_LOG2'(N_LOG2 - 1)) ? stage_q : stage_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Write-back is the read issue delayed by the RAM/ROM latency.
  always_comb begin
    den_d    = den_q;
    dwa_d    = dwa_q;
    dwb_d    = dwb_q;
    den_d[0] = rd_en;
    dwa_d[0] = rd_addr_a;
    dwb_d[0] = rd_addr_b;
    for (int i = 1; i < RD_LAT; i++) begin
      den_d[i] = den_q[i-1];
      dwa_d[i] = dwa_q[i-1];
      dwb_d[i] = dwb_q[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      den_q   <= '0;
      dwa_q   <= '0;
      dwb_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      den_q   <= den_d;
      dwa_q   <= dwa_d;
      dwb_q   <= dwb_d;
    end
  end
endmodule

// File: tb/tb_fft_stage_seq.sv
// tb_fft_stage_seq: checks two sequencers (RD_LAT 1 and 3) against a cycle-indexed FFT schedule model.
module tb_fft_stage_seq;
  localparam int NL = 4;
  localparam int N = 16;
  logic clk = 0, rst_n = 0, start = 0;
  logic busy1, done1, rd1, wr1, busy3, done3, rd3, wr3;
  logic [3:0] ra1, rb1, wa1, wb1, st1, ra3, rb3, wa3, wb3, st3;
  logic [2:0] tw1, tw3;
  int checks = 0, failures = 0;

  fft_stage_seq #(.N_LOG2(4), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
    .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1),
    .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1), .stage(st1));
  fft_stage_seq #(.N_LOG2(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy3), .done(done3),
    .rd_en(rd3), .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_addr(tw3),
    .wr_en(wr3), .wr_addr_a(wa3), .wr_addr_b(wb3), .stage(st3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Butterfly issued in cycle c (cycle 1 follows the edge that took start).
  function automatic void issue(input int lat, input int c, output bit v,
                                output int a, output int b, output int tw);
    int p, idx, s, k, span;
    p = N / 2 + lat;
    v = 0; a = 0; b = 0; tw = 0;
    if (c >= 1) begin
      idx = c - 1; s = idx / p; k = idx % p;
      if (s < NL && k < N / 2) begin
        v = 1;
        span = 1 << s;
        a = ((k >> s) << (s + 1)) | (k & (span - 1));
        b = a + span;
        tw = (k & (span - 1)) << (NL - 1 - s);
      end
    end
  endfunction

  task automatic check_dut(input string p, input int lat, input int c, input bit ab,
                           input logic rd, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [2:0] tw, input logic wr, input logic [3:0] wa,
                           input logic [3:0] wb, input logic dn, input logic bs,
                           input logic [3:0] st);
    bit erd, ewr;
    int ea, eb, etw, ewa, ewb, ed, tot, est, ebs;
    tot = NL * (N / 2 + lat);
    issue(lat, c, erd, ea, eb, etw);
    issue(lat, c - lat, ewr, ewa, ewb, ed);
    ebs = c >= 1 && c <= tot + 1;
    est = (c >= 1 && c <= tot) ? (c - 1) / (N / 2 + lat) : (c == tot + 1 ? NL - 1 : 0);
    if (ab) begin
      erd = 0; ewr = 0; ebs = 0; est = 0; tot = -5;
      chk({p, "rst_rd_addr"}, {ra, rb, 1'b0, tw}, 0);
      chk({p, "rst_wr_addr"}, {wa, wb}, 0);
    end
    chk({p, "rd_en"}, rd, erd);
    if (erd) begin
      chk({p, "rd_addr_a"}, ra, ea);
      chk({p, "rd_addr_b"}, rb, eb);
      chk({p, "tw_addr"}, tw, etw);
    end
    chk({p, "wr_en"}, wr, ewr);
    if (ewr) begin
      chk({p, "wr_addr_a"}, wa, ewa);
      chk({p, "wr_addr_b"}, wb, ewb);
    end
    chk({p, "done"}, dn, c == tot + 1);
    chk({p, "busy"}, bs, ebs);
    chk({p, "stage"}, st, est);
  endtask

  task automatic run(input int rst_c, input int xs);
    bit ab = 0;
    int mask [NL];
    int nw [NL];
    int d1 = -1, d3 = -1, tw_all = 0;
    for (int s = 0; s < NL; s++) begin mask[s] = 0; nw[s] = 0; end
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #2 start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c == rst_c) begin rst_n = 0; #1; ab = 1; end
      if (ab && c == rst_c + 3) rst_n = 1;
      check_dut("l1_", 1, c, ab, rd1, ra1, rb1, tw1, wr1, wa1, wb1, done1, busy1, st1);
      check_dut("l3_", 3, c, ab, rd3, ra3, rb3, tw3, wr3, wa3, wb3, done3, busy3, st3);
      if (!ab) begin
        if (c == 4) chk("s0k3_abt", {ra1, rb1, 1'b0, tw1}, {4'd6, 4'd7, 4'd0});
        if (c == 24) chk("s2k5_abt", {ra1, rb1, 1'b0, tw1}, {4'd9, 4'd13, 4'd2});
        if (c == 35) chk("s3k7_abt", {ra1, rb1, 1'b0, tw1}, {4'd7, 4'd15, 4'd7});
        if (wr1 && c >= 2 && (c - 2) / 9 < NL) begin
          mask[(c - 2) / 9] |= (1 << wa1) | (1 << wb1);
          nw[(c - 2) / 9]++;
          tw_all++;
        end
        if (done1 && d1 < 0) d1 = c;
        if (done3 && d3 < 0) d3 = c;
      end
      start = !ab && (c == 12 || c == xs);
      @(posedge clk);
      #1;
    end
    start = 0;
    if (!ab) begin
      for (int s = 0; s < NL; s++) begin
        chk("stage_cover", mask[s], 16'hffff);
        chk("stage_writes", nw[s], N / 2);
      end
      chk("total_writes", tw_all, 32);
      chk("done_cycle_l1", d1, 37);
      chk("done_cycle_l3", d3, 45);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_dut("init1_", 1, 0, 1, rd1, ra1, rb1, tw1, wr1, wa1, wb1, done1, busy1, st1);
    check_dut("init3_", 3, 0, 1, rd3, ra3, rb3, tw3, wr3, wa3, wb3, done3, busy3, st3);
    rst_n = 1;
    run(0, $urandom_range(2, 37));
    run(20, 0);
    run(0, 0);
    run($urandom_range(2, 44), 0);
    run(0, $urandom_range(13, 37));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
